// File: rtl/uart_core_pkg.sv
// uart_core_pkg
// Shared types and helpers for the uart_core transmit and receive engines.
//   tx_state_e   : transmit frame sequencer states
//   rx_state_e   : receive frame sequencer states
//   clksPerBit   : integer-truncated system clocks per serial bit
//   cntWidth     : bit counter width able to hold clksPerBit-1
package uart_core_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_CLEANUP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic int clksPerBit(input int clkHz, input int baudRate);
    return clkHz / baudRate;
  endfunction

  // A divider of 1 still needs a one-bit counter.
  function automatic int cntWidth(input int cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx
// Deserialises 8N1 frames sampled at bit centres.
//   clk_i       : system clock, rising edge
//   rst_ni      : synchronous active-low reset
//   rxSerial_i  : asynchronous serial line, idles high
//   rxValid_o   : one-cycle pulse when a well-framed byte arrives
//   rxData_o    : last good byte, held until the next good frame
module uart_rx #(
  parameter int CLKS_PER_BIT = 1041
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxSerial_i,
  output logic       rxValid_o,
  output logic [7:0] rxData_o
);
  import uart_core_pkg::*;

  localparam int CW = cntWidth(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] clkCnt_q, clkCnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rxData_q, rxData_d;
  logic          rxValid_q, rxValid_d;
  logic          armed_q, armed_d;
  logic          rxMeta_q, rxSync_q;

  // Two-flop synchroniser; both stages reset to the idle level.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rxSerial_i;
      rxSync_q <= rxMeta_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= RX_IDLE;
      clkCnt_q  <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      rxData_q  <= '0;
      rxValid_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clkCnt_q  <= clkCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      rxData_q  <= rxData_d;
      rxValid_q <= rxValid_d;
      armed_q   <= armed_d;
    end
  end

  // armed_q records that the line has been seen high since the last frame,
  // so a framing error (line still low) or a reset mid-frame cannot be
  // mistaken for a new start bit. A good stop bit arms immediately, which
  // lets back-to-back frames through.
  always_comb begin
    state_d   = state_q;
    clkCnt_d  = clkCnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    rxData_d  = rxData_q;
    rxValid_d = 1'b0;
    armed_d   = armed_q;
    case (state_q)
      RX_IDLE: begin
        clkCnt_d = '0;
        bitIdx_d = '0;
        if (rxSync_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (clkCnt_q == HALF_CNT) begin
          clkCnt_d = '0;
          if (!rxSync_q) begin
            state_d = RX_DATA;
          end else begin
            armed_d = 1'b1;
            state_d = RX_IDLE;
          end
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (clkCnt_q == LAST_CNT) begin
          clkCnt_d = '0;
          shift_d  = {rxSync_q, shift_q[7:1]};
          if (bitIdx_q == 3'd7) begin
            bitIdx_d = '0;
            state_d  = RX_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (clkCnt_q == LAST_CNT) begin
          clkCnt_d = '0;
          state_d  = RX_IDLE;
          if (rxSync_q) begin
            rxData_d  = shift_q;
            rxValid_d = 1'b1;
            armed_d   = 1'b1;
          end
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign rxValid_o = rxValid_q;
  assign rxData_o  = rxData_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// Serialises one byte per accepted request as an 8N1 frame.
//   clk_i       : system clock, rising edge
//   rst_ni      : synchronous active-low reset
//   txValid_i   : request, sampled only while idle
//   txData_i    : byte latched with an accepted request
//   txActive_o  : high while the frame is on the line
//   txSerial_o  : serial line, idles high
//   txDone_o    : one-cycle pulse after the stop bit
module uart_tx #(
  parameter int CLKS_PER_BIT = 1041
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       txValid_i,
  input  logic [7:0] txData_i,
  output logic       txActive_o,
  output logic       txSerial_o,
  output logic       txDone_o
);
  import uart_core_pkg::*;

  localparam int CW = cntWidth(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] clkCnt_q, clkCnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    data_q, data_d;
  logic          txSerial_q, txSerial_d;
  logic          txActive_q, txActive_d;
  logic          txDone_q, txDone_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= TX_IDLE;
      clkCnt_q   <= '0;
      bitIdx_q   <= '0;
      data_q     <= '0;
      txSerial_q <= 1'b1;
      txActive_q <= 1'b0;
      txDone_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clkCnt_q   <= clkCnt_d;
      bitIdx_q   <= bitIdx_d;
      data_q     <= data_d;
      txSerial_q <= txSerial_d;
      txActive_q <= txActive_d;
      txDone_q   <= txDone_d;
    end
  end

  // Every timed state counts from zero and leaves on the last count,
  // so each one lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_d  = state_q;
    clkCnt_d = clkCnt_q;
    bitIdx_d = bitIdx_q;
    data_d   = data_q;
    case (state_q)
      TX_IDLE: begin
        clkCnt_d = '0;
        bitIdx_d = '0;
        if (txValid_i) begin
          data_d  = txData_i;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (clkCnt_q == LAST_CNT) begin
          clkCnt_d = '0;
          state_d  = TX_DATA;
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (clkCnt_q == LAST_CNT) begin
          clkCnt_d = '0;
          if (bitIdx_q == 3'd7) begin
            bitIdx_d = '0;
            state_d  = TX_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (clkCnt_q == LAST_CNT) begin
          clkCnt_d = '0;
          state_d  = TX_CLEANUP;
        end else begin
          clkCnt_d = clkCnt_q + CW'(1);
        end
      end
      TX_CLEANUP: begin
        state_d = TX_IDLE;
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

  // Pin values are decoded from the current state and registered, so the
  // line changes one cycle after the state does and never glitches.
  always_comb begin
    txSerial_d = 1'b1;
    txActive_d = 1'b0;
    txDone_d   = 1'b0;
    case (state_q)
      TX_START: begin
        txSerial_d = 1'b0;
        txActive_d = 1'b1;
      end
      TX_DATA: begin
        txSerial_d = data_q[bitIdx_q];
        txActive_d = 1'b1;
      end
      TX_STOP: begin
        txActive_d = 1'b1;
      end
      TX_CLEANUP: begin
        txDone_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign txSerial_o = txSerial_q;
  assign txActive_o = txActive_q;
  assign txDone_o   = txDone_q;

endmodule

// File: rtl/uart_core.sv
// uart_core
// Full-duplex 8N1 UART endpoint with independent transmit and receive
// engines sharing one clock and a fixed integer baud divider.
//   source_clk   : system clock
//   rst_n        : synchronous active-low reset
//   i_tx_valid   : transmit request (ignored while a frame is in flight)
//   tx_message   : byte to transmit
//   tx_active    : transmit frame on the line
//   tx_serial    : serial output
//   done         : transmit completion pulse
//   i_rx_serial  : serial input
//   o_rx_valid   : receive pulse
//   o_RX_message : last received byte
module uart_core #(
  parameter int BAUD_RATE = 9600,
  parameter int CLK_HZ    = 10_000_000
) (
  input  logic       source_clk,
  input  logic       rst_n,
  input  logic       i_tx_valid,
  input  logic [7:0] tx_message,
  output logic       tx_active,
  output logic       tx_serial,
  output logic       done,
  input  logic       i_rx_serial,
  output logic       o_rx_valid,
  output logic [7:0] o_RX_message
);
  import uart_core_pkg::*;

  localparam int CLKS_PER_BIT = clksPerBit(CLK_HZ, BAUD_RATE);

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_i      (source_clk),
    .rst_ni     (rst_n),
    .txValid_i  (i_tx_valid),
    .txData_i   (tx_message),
    .txActive_o (tx_active),
    .txSerial_o (tx_serial),
    .txDone_o   (done)
  );

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i      (source_clk),
    .rst_ni     (rst_n),
    .rxSerial_i (i_rx_serial),
    .rxValid_o  (o_rx_valid),
    .rxData_o   (o_RX_message)
  );

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core
// Self-checking bench for uart_core. A reduced clock rate keeps frames short
// (1_000_000 / 9600 truncates to 104 clocks per bit).
module tb_uart_core;

  localparam int CLK_HZ    = 1_000_000;
  localparam int BAUD_RATE = 9600;
  localparam int CPB       = CLK_HZ / BAUD_RATE;
  localparam int FRAME     = 10 * CPB;

  logic       source_clk = 1'b0;
  logic       rst_n      = 1'b0;
  logic       i_tx_valid = 1'b0;
  logic [7:0] tx_message = 8'h00;
  logic       tx_active;
  logic       tx_serial;
  logic       done;
  logic       i_rx_serial;
  logic       o_rx_valid;
  logic [7:0] o_RX_message;

  logic rxDrive  = 1'b1;
  logic loopback = 1'b0;

  assign i_rx_serial = loopback ? tx_serial : rxDrive;

  always #5 source_clk = ~source_clk;

  uart_core #(
    .BAUD_RATE(BAUD_RATE),
    .CLK_HZ   (CLK_HZ)
  ) dut (
    .source_clk  (source_clk),
    .rst_n       (rst_n),
    .i_tx_valid  (i_tx_valid),
    .tx_message  (tx_message),
    .tx_active   (tx_active),
    .tx_serial   (tx_serial),
    .done        (done),
    .i_rx_serial (i_rx_serial),
    .o_rx_valid  (o_rx_valid),
    .o_RX_message(o_RX_message)
  );

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int doneCount   = 0;
  int validCount  = 0;

  // Transmit model: the edge a request was accepted and the byte it carried.
  bit         txHas  = 1'b0;
  int         txAcc  = 0;
  logic [7:0] txByte = 8'h00;

  // Receive model: expected bytes with the window of edges their pulse may
  // appear in, plus the byte the output must hold between pulses.
  typedef struct {
    int         lo;
    int         hi;
    logic [7:0] data;
  } rxEvent_t;
  rxEvent_t   rxQ[$];
  logic [7:0] heldMsg = 8'h00;

  logic [9:0] obs;
  int         v0;
  int         d0;

  function automatic logic frameBit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // firstLowEdge is the first clock edge at which the pin is sampled low;
  // the pulse is due about 9.5 bit times plus 3 clocks later.
  function automatic rxEvent_t mkEvent(input int firstLowEdge, input logic [7:0] d);
    rxEvent_t ev;
    int center;
    center  = firstLowEdge + (19 * CPB) / 2 + 3;
    ev.lo   = center - CPB / 8;
    ev.hi   = center + CPB / 8;
    ev.data = d;
    return ev;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model update on every rising edge, using the inputs the DUT samples there.
  always @(posedge source_clk) begin
    cyc++;
    if (!rst_n) begin
      txHas   = 1'b0;
      heldMsg = 8'h00;
      rxQ.delete();
    end else if (i_tx_valid && (!txHas || cyc >= txAcc + FRAME + 2)) begin
      txHas  = 1'b1;
      txAcc  = cyc;
      txByte = tx_message;
      if (loopback) rxQ.push_back(mkEvent(cyc + 2, tx_message));
    end
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge source_clk) begin : compare
    int   j;
    logic expSer;
    logic expAct;
    logic expDone;
    expSer  = 1'b1;
    expAct  = 1'b0;
    expDone = 1'b0;
    if (txHas) begin
      j = cyc - (txAcc + 1);
      if (j >= 0 && j < FRAME) begin
        expSer = frameBit(txByte, j / CPB);
        expAct = 1'b1;
      end else if (j == FRAME) begin
        expDone = 1'b1;
      end
    end
    checkOutput("tx_serial", {31'd0, tx_serial}, {31'd0, expSer});
    checkOutput("tx_active", {31'd0, tx_active}, {31'd0, expAct});
    checkOutput("done", {31'd0, done}, {31'd0, expDone});
    if (done === 1'b1) doneCount++;
    if (o_rx_valid === 1'b1) begin
      validCount++;
      if (rxQ.size() == 0 || cyc < rxQ[0].lo) begin
        checkOutput("rx_valid_unexpected", {31'd0, o_rx_valid}, 32'd0);
      end else begin
        checkOutput("rx_data", {24'd0, o_RX_message}, {24'd0, rxQ[0].data});
        heldMsg = rxQ[0].data;
        void'(rxQ.pop_front());
      end
    end else begin
      checkOutput("rx_held", {24'd0, o_RX_message}, {24'd0, heldMsg});
      if (rxQ.size() > 0 && cyc > rxQ[0].hi) begin
        checkOutput("rx_valid_missing", {31'd0, o_rx_valid}, 32'd1);
        void'(rxQ.pop_front());
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge source_clk);
  endtask

  // Called on a falling edge; the request is sampled at the next rising edge.
  task automatic applyStimulus(input logic [7:0] msg);
    i_tx_valid = 1'b1;
    tx_message = msg;
    @(negedge source_clk);
    i_tx_valid = 1'b0;
    tx_message = 8'($urandom);
  endtask

  task automatic waitTxDone(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge source_clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput("tx_done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Called on a falling edge; drives a whole frame and returns on the
  // falling edge where the stop bit has just ended.
  task automatic driveRxFrame(input logic [7:0] data, input logic stopBit);
    for (int i = 0; i < 10; i++) begin
      rxDrive = (i == 9) ? stopBit : frameBit(data, i);
      if (i == 0 && stopBit) rxQ.push_back(mkEvent(cyc + 1, data));
      repeat (CPB) @(negedge source_clk);
    end
    rxDrive = 1'b1;
  endtask

  initial begin
    repeat (4) @(negedge source_clk);
    checkOutput("reset_tx_serial", {31'd0, tx_serial}, 32'd1);
    checkOutput("reset_tx_active", {31'd0, tx_active}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_rx_valid", {31'd0, o_rx_valid}, 32'd0);
    checkOutput("reset_rx_message", {24'd0, o_RX_message}, 32'h00);
    rst_n = 1'b1;
    waitCycles(3);

    // TX 0xAB, sampling the line at the centre of every bit.
    d0 = doneCount;
    applyStimulus(8'hAB);
    waitCycles(1);
    for (int b = 0; b < 10; b++) begin
      waitCycles(CPB / 2);
      obs[b] = tx_serial;
      waitCycles(CPB - CPB / 2);
    end
    checkOutput("tx_AB_bits", {22'd0, obs}, {22'd0, 10'b11_0101_0110});
    waitCycles(2);
    checkOutput("tx_AB_done_pulses", doneCount - d0, 32'd1);

    // RX 0x3F.
    v0 = validCount;
    driveRxFrame(8'h3F, 1'b1);
    waitCycles(1);
    checkOutput("rx_3F_message", {24'd0, o_RX_message}, 32'h3F);
    checkOutput("rx_3F_pulses", validCount - v0, 32'd1);

    // Short low glitch, then a real 0xA5 frame.
    v0 = validCount;
    rxDrive = 1'b0;
    waitCycles(20);
    rxDrive = 1'b1;
    waitCycles(CPB);
    checkOutput("rx_glitch_pulses", validCount - v0, 32'd0);
    driveRxFrame(8'hA5, 1'b1);
    waitCycles(1);
    checkOutput("rx_A5_message", {24'd0, o_RX_message}, 32'hA5);
    checkOutput("rx_A5_pulses", validCount - v0, 32'd1);

    // Framing error: 0x55 with a low stop bit is discarded.
    v0 = validCount;
    driveRxFrame(8'h55, 1'b0);
    waitCycles(2 * CPB);
    checkOutput("rx_framing_pulses", validCount - v0, 32'd0);
    checkOutput("rx_framing_message", {24'd0, o_RX_message}, 32'hA5);

    // Busy request ignored, then the earliest follow-on request, in loopback.
    loopback = 1'b1;
    v0 = validCount;
    applyStimulus(8'h9E);
    waitCycles(3 * CPB);
    applyStimulus(8'h12);
    waitTxDone(FRAME + 20);
    applyStimulus(8'h34);
    waitTxDone(FRAME + 20);
    waitCycles(CPB);
    loopback = 1'b0;
    checkOutput("loop_34_message", {24'd0, o_RX_message}, 32'h34);
    checkOutput("loop_pulses", validCount - v0, 32'd2);

    // Reset during TX data bit 3 and RX data bit 5.
    v0 = validCount;
    d0 = doneCount;
    for (int i = 0; i < 8 * CPB; i++) begin
      rxDrive = frameBit(8'h96, i / CPB);
      if (i == 2 * CPB) begin
        i_tx_valid = 1'b1;
        tx_message = 8'h5A;
      end
      if (i == 2 * CPB + 1) i_tx_valid = 1'b0;
      if (i == 6 * CPB + CPB / 2) rst_n = 1'b0;
      if (i == 6 * CPB + CPB / 2 + 1) begin
        checkOutput("rst_mid_tx_serial", {31'd0, tx_serial}, 32'd1);
        checkOutput("rst_mid_tx_active", {31'd0, tx_active}, 32'd0);
        checkOutput("rst_mid_done", {31'd0, done}, 32'd0);
        checkOutput("rst_mid_rx_valid", {31'd0, o_rx_valid}, 32'd0);
      end
      if (i == 6 * CPB + CPB / 2 + 2) begin
        rst_n   = 1'b1;
        rxDrive = 1'b1;
        break;
      end
      @(negedge source_clk);
    end
    waitCycles(2 * CPB);
    checkOutput("rst_mid_no_rx_pulse", validCount - v0, 32'd0);
    checkOutput("rst_mid_no_done", doneCount - d0, 32'd0);
    checkOutput("rst_mid_message", {24'd0, o_RX_message}, 32'h00);
    loopback = 1'b1;
    applyStimulus(8'hC3);
    waitTxDone(FRAME + 20);
    waitCycles(CPB);
    loopback = 1'b0;
    checkOutput("loop_C3_message", {24'd0, o_RX_message}, 32'hC3);

    // Random traffic on both engines at once.
    fork
      begin
        for (int n = 0; n < 6; n++) begin
          applyStimulus(8'($urandom));
          waitTxDone(FRAME + 20);
          waitCycles($urandom_range(0, 40));
        end
      end
      begin
        for (int n = 0; n < 8; n++) begin
          logic stopBit;
          stopBit = ($urandom_range(0, 4) != 0);
          driveRxFrame(8'($urandom), stopBit);
          if (!stopBit) waitCycles(CPB);
          else if ($urandom_range(0, 1) == 1) waitCycles($urandom_range(1, 30));
        end
      end
    join

    // Random back-to-back loopback frames.
    waitCycles(CPB);
    loopback = 1'b1;
    for (int n = 0; n < 4; n++) begin
      applyStimulus(8'($urandom));
      waitTxDone(FRAME + 20);
    end
    waitCycles(CPB);
    loopback = 1'b0;

    for (int i = 0; i < 3 * FRAME && rxQ.size() > 0; i++) @(negedge source_clk);
    checkOutput("rx_queue_drained", rxQ.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge source_clk);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
